// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch/decode sequencer driving an external program counter,
//               with a 4-entry return stack and HALT/ERROR states.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] CounterValue,
    output logic        FetchReq,
    input  logic        FetchAck,
    output logic        CommandReady,
    input  logic        CommandValid,
    input  logic [2:0]  Command,
    input  logic [15:0] Target,
    input  logic [8:0]  BranchOffset,
    input  logic        Condition,
    input  logic        Resume,
    output logic [15:0] LoadValue,
    output logic        LoadEnable,
    output logic [8:0]  Offset,
    output logic        OffsetEnable,
    output logic        Halted,
    output logic        StackError,
    output logic [2:0]  StackDepth
);

    localparam logic [1:0] c_FETCH  = 2'd0;
    localparam logic [1:0] c_DECODE = 2'd1;
    localparam logic [1:0] c_HALT   = 2'd2;
    localparam logic [1:0] c_ERROR  = 2'd3;

    localparam logic [2:0] c_NOP    = 3'd0;
    localparam logic [2:0] c_JUMP   = 3'd1;
    localparam logic [2:0] c_BRANCH = 3'd2;
    localparam logic [2:0] c_CALL   = 3'd3;
    localparam logic [2:0] c_RET    = 3'd4;
    localparam logic [2:0] c_HLT    = 3'd5;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [2:0]  r_depth;
    logic [15:0] r_stack [0:3];

    logic        w_exec;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_top;

    assign w_exec  = (r_state == c_DECODE) && CommandValid;
    assign w_full  = (r_depth == 3'd4);
    assign w_empty = (r_depth == 3'd0);
    assign w_push  = w_exec && (Command == c_CALL) && !w_full;
    assign w_pop   = w_exec && (Command == c_RET) && !w_empty;
    // Depth 4 wraps to index 0, so top-of-stack minus one lands on entry 3.
    assign w_top   = r_depth[1:0] - 2'd1;

    assign StackDepth = r_depth;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_depth <= 3'd0;
        end else if (w_push) begin
            r_stack[r_depth[1:0]] <= CounterValue + 16'd1;
            r_depth               <= r_depth + 3'd1;
        end else if (w_pop) begin
            r_depth <= r_depth - 3'd1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_FETCH: begin
                if (FetchAck) begin
                    w_next_state = c_DECODE;
                end
            end
            c_DECODE: begin
                if (CommandValid) begin
                    if ((Command == c_CALL && w_full) || (Command == c_RET && w_empty)) begin
                        w_next_state = c_ERROR;
                    end else if (Command == c_HLT) begin
                        w_next_state = c_HALT;
                    end else begin
                        w_next_state = c_FETCH;
                    end
                end
            end
            c_HALT: begin
                if (Resume) begin
                    w_next_state = c_FETCH;
                end
            end
            default: w_next_state = c_ERROR;
        endcase
    end

    // Default output set is "Hold": keep the PC where it is.
    always_comb begin
        FetchReq     = 1'b0;
        CommandReady = 1'b0;
        LoadValue    = 16'd0;
        LoadEnable   = 1'b0;
        Offset       = 9'd0;
        OffsetEnable = 1'b1;
        Halted       = 1'b0;
        StackError   = 1'b0;
        if (!Reset) begin
            case (r_state)
                c_FETCH: begin
                    FetchReq = 1'b1;
                end
                c_DECODE: begin
                    CommandReady = 1'b1;
                    if (CommandValid) begin
                        case (Command)
                            c_JUMP: begin
                                LoadValue    = Target;
                                LoadEnable   = 1'b1;
                                OffsetEnable = 1'b0;
                            end
                            c_BRANCH: begin
                                if (Condition) begin
                                    Offset = BranchOffset;
                                end else begin
                                    OffsetEnable = 1'b0;
                                end
                            end
                            c_CALL: begin
                                if (!w_full) begin
                                    LoadValue    = Target;
                                    LoadEnable   = 1'b1;
                                    OffsetEnable = 1'b0;
                                end
                            end
                            c_RET: begin
                                if (!w_empty) begin
                                    LoadValue    = r_stack[w_top];
                                    LoadEnable   = 1'b1;
                                    OffsetEnable = 1'b0;
                                end
                            end
                            c_HLT: begin
                                OffsetEnable = 1'b1;
                            end
                            default: begin
                                OffsetEnable = 1'b0;
                            end
                        endcase
                    end
                end
                c_HALT: begin
                    Halted = 1'b1;
                    if (Resume) begin
                        OffsetEnable = 1'b0;
                    end
                end
                default: begin
                    StackError = 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Vector-table bench for pc_sequencer with a behavioural PC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] CounterValue;
    logic        FetchReq;
    logic        FetchAck = 1'b0;
    logic        CommandReady;
    logic        CommandValid = 1'b0;
    logic [2:0]  Command = 3'd0;
    logic [15:0] Target = 16'd0;
    logic [8:0]  BranchOffset = 9'd0;
    logic        Condition = 1'b0;
    logic        Resume = 1'b0;
    logic [15:0] LoadValue;
    logic        LoadEnable;
    logic [8:0]  Offset;
    logic        OffsetEnable;
    logic        Halted;
    logic        StackError;
    logic [2:0]  StackDepth;

    int n_vec = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    pc_sequencer dut (
        .Clock(Clock), .Reset(Reset), .CounterValue(CounterValue),
        .FetchReq(FetchReq), .FetchAck(FetchAck), .CommandReady(CommandReady),
        .CommandValid(CommandValid), .Command(Command), .Target(Target),
        .BranchOffset(BranchOffset), .Condition(Condition), .Resume(Resume),
        .LoadValue(LoadValue), .LoadEnable(LoadEnable), .Offset(Offset),
        .OffsetEnable(OffsetEnable), .Halted(Halted), .StackError(StackError),
        .StackDepth(StackDepth)
    );

    // The attached program counter.
    always_ff @(posedge Clock) begin
        if (Reset)             CounterValue <= 16'd0;
        else if (LoadEnable)   CounterValue <= LoadValue;
        else if (OffsetEnable) CounterValue <= CounterValue + {{7{Offset[8]}}, Offset};
        else                   CounterValue <= CounterValue + 16'd1;
    end

    always @(negedge Clock) begin
        if (LoadEnable === 1'b1 && OffsetEnable === 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL strobe_exclusive: LoadEnable=1 OffsetEnable=1, required not both");
        end
    end

    typedef struct {
        string       name;
        logic        rst, ack, cv;
        logic [2:0]  cmd;
        logic [15:0] tgt;
        logic [8:0]  off;
        logic        cond, res;
        logic        freq, crdy, halt, err;
        logic [15:0] pc;
        logic [2:0]  depth;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(string name, logic rst, logic ack, logic cv, logic [2:0] cmd,
                                logic [15:0] tgt, logic [8:0] off, logic cond, logic res,
                                logic freq, logic crdy, logic halt, logic err,
                                logic [15:0] pc, logic [2:0] depth);
        vec_t v;
        v.name = name; v.rst = rst; v.ack = ack; v.cv = cv; v.cmd = cmd; v.tgt = tgt;
        v.off = off; v.cond = cond; v.res = res; v.freq = freq; v.crdy = crdy;
        v.halt = halt; v.err = err; v.pc = pc; v.depth = depth;
        tbl.push_back(v);
    endfunction

    function automatic void vf(string name, logic [15:0] pc, logic [2:0] depth);
        add(name, 0, 1, 0, 3'd0, 16'd0, 9'd0, 0, 0, 1, 0, 0, 0, pc, depth);
    endfunction

    function automatic void vd(string name, logic [2:0] cmd, logic [15:0] tgt, logic [8:0] off,
                               logic cond, logic [15:0] pc, logic [2:0] depth);
        add(name, 0, 0, 1, cmd, tgt, off, cond, 0, 0, 1, 0, 0, pc, depth);
    endfunction

    initial begin
        logic fq, cr, ht, er;

        add("reset0", 1, 0, 0, 3'd0, 16'd0, 9'd0, 0, 0, 0, 0, 0, 0, 16'd0, 3'd0);
        add("reset1", 1, 1, 1, 3'd1, 16'd9, 9'd0, 0, 1, 0, 0, 0, 0, 16'd0, 3'd0);
        vf("nop_f0", 16'd0, 0); vd("nop_d0", 3'd0, 0, 0, 0, 16'd1, 0);
        vf("nop_f1", 16'd1, 0); vd("nop_d1", 3'd0, 0, 0, 0, 16'd2, 0);
        vf("nop_f2", 16'd2, 0); vd("nop_d2", 3'd0, 0, 0, 0, 16'd3, 0);
        add("fetch_ignores_cmd", 0, 1, 1, 3'd1, 16'd2023, 9'd0, 0, 0, 1, 0, 0, 0, 16'd3, 0);
        vd("jump_2023", 3'd1, 16'd2023, 0, 0, 16'd2023, 0);
        vf("f_br1", 16'd2023, 0); vd("branch_taken", 3'd2, 0, 9'h1FB, 1, 16'd2018, 0);
        vf("f_br0", 16'd2018, 0); vd("branch_not", 3'd2, 0, 9'h1FB, 0, 16'd2019, 0);
        vf("f_jffff", 16'd2019, 0); vd("jump_ffff", 3'd1, 16'hFFFF, 0, 0, 16'hFFFF, 0);
        vf("f_wrap", 16'hFFFF, 0); vd("nop_wrap", 3'd0, 0, 0, 0, 16'h0000, 0);
        vf("f_rsv", 16'h0000, 0); vd("reserved6", 3'd6, 16'h5555, 9'h0AA, 1, 16'h0001, 0);
        vf("f_j10", 16'h0001, 0); vd("jump_0010", 3'd1, 16'h0010, 0, 0, 16'h0010, 0);
        vf("f_call", 16'h0010, 0); vd("call_0100", 3'd3, 16'h0100, 0, 0, 16'h0100, 1);
        vf("f_ret", 16'h0100, 1); vd("ret_0011", 3'd4, 0, 0, 0, 16'h0011, 0);
        vf("f_wait", 16'h0011, 0);
        add("decode_wait0", 0, 0, 0, 3'd1, 16'hABCD, 0, 0, 0, 0, 1, 0, 0, 16'h0011, 0);
        add("decode_wait1", 0, 1, 0, 3'd0, 16'd0, 0, 0, 0, 0, 1, 0, 0, 16'h0011, 0);
        vd("decode_nop", 3'd0, 0, 0, 0, 16'h0012, 0);
        vf("f_j7", 16'h0012, 0); vd("jump_7", 3'd1, 16'd7, 0, 0, 16'd7, 0);
        vf("f_halt", 16'd7, 0); vd("halt_cmd", 3'd5, 0, 0, 0, 16'd7, 0);
        for (int i = 0; i < 10; i++)
            add("halt_hold", 0, 1, 1, 3'd1, 16'd99, 0, 0, 0, 0, 0, 1, 0, 16'd7, 0);
        add("halt_resume", 0, 0, 0, 3'd0, 16'd0, 0, 0, 1, 0, 0, 1, 0, 16'd8, 0);
        vf("resume_to_fetch", 16'd8, 0);
        vd("nop_9", 3'd0, 0, 0, 0, 16'd9, 0);
        for (int i = 0; i < 10; i++)
            add("fetch_stall", 0, 0, 1, 3'd1, 16'd5, 0, 0, 0, 1, 0, 0, 0, 16'd9, 0);
        vf("fetch_ack", 16'd9, 0);
        vd("call_0200", 3'd3, 16'h0200, 0, 0, 16'h0200, 1);
        vf("f_c2", 16'h0200, 1); vd("call_0300", 3'd3, 16'h0300, 0, 0, 16'h0300, 2);
        vf("f_rst", 16'h0300, 2);
        add("reset_in_decode", 1, 0, 1, 3'd3, 16'h0400, 0, 0, 0, 0, 0, 0, 0, 16'd0, 0);
        vf("fetch_after_rst", 16'd0, 0);
        vd("call1", 3'd3, 16'h1000, 0, 0, 16'h1000, 1);
        vf("f_c2b", 16'h1000, 1); vd("call2", 3'd3, 16'h2000, 0, 0, 16'h2000, 2);
        vf("f_c3", 16'h2000, 2); vd("call3", 3'd3, 16'h3000, 0, 0, 16'h3000, 3);
        vf("f_c4", 16'h3000, 3); vd("call4", 3'd3, 16'h4000, 0, 0, 16'h4000, 4);
        vf("f_r4", 16'h4000, 4); vd("ret_from_4", 3'd4, 0, 0, 0, 16'h3001, 3);
        vf("f_c4b", 16'h3001, 3); vd("call4_again", 3'd3, 16'h4000, 0, 0, 16'h4000, 4);
        vf("f_c5", 16'h4000, 4); vd("call5_overflow", 3'd3, 16'h5000, 0, 0, 16'h4000, 4);
        add("error_ignores", 0, 1, 1, 3'd1, 16'h1234, 0, 0, 1, 0, 0, 0, 1, 16'h4000, 4);
        add("error_sticky", 0, 1, 1, 3'd4, 16'h1234, 0, 0, 1, 0, 0, 0, 1, 16'h4000, 4);
        add("reset_clears_err", 1, 0, 0, 3'd0, 16'd0, 0, 0, 0, 0, 0, 0, 0, 16'd0, 0);
        vf("f_ret0", 16'd0, 0); vd("ret_underflow", 3'd4, 0, 0, 0, 16'd0, 0);
        add("error_after_ret", 0, 1, 1, 3'd0, 16'd0, 0, 0, 1, 0, 0, 0, 1, 16'd0, 0);
        add("reset_final", 1, 0, 0, 3'd0, 16'd0, 0, 0, 0, 0, 0, 0, 0, 16'd0, 0);

        foreach (tbl[i]) begin
            Reset = tbl[i].rst; FetchAck = tbl[i].ack; CommandValid = tbl[i].cv;
            Command = tbl[i].cmd; Target = tbl[i].tgt; BranchOffset = tbl[i].off;
            Condition = tbl[i].cond; Resume = tbl[i].res;
            @(negedge Clock);
            fq = FetchReq; cr = CommandReady; ht = Halted; er = StackError;
            @(posedge Clock);
            #1;
            n_vec++;
            if (fq !== tbl[i].freq || cr !== tbl[i].crdy || ht !== tbl[i].halt ||
                er !== tbl[i].err || CounterValue !== tbl[i].pc || StackDepth !== tbl[i].depth) begin
                n_bad++;
                $display("FAIL %s[%0d]: got freq=%b crdy=%b halt=%b err=%b pc=%h depth=%0d, want freq=%b crdy=%b halt=%b err=%b pc=%h depth=%0d",
                         tbl[i].name, i, fq, cr, ht, er, CounterValue, StackDepth,
                         tbl[i].freq, tbl[i].crdy, tbl[i].halt, tbl[i].err, tbl[i].pc, tbl[i].depth);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
